dmem_mmio: RTL and testbench
============================

# dmem_mmio

Data-side responder for the single-cycle ARM core: it answers the core's data-memory port (address, write strobe, write data, read data) with a word RAM plus a small memory-mapped I/O window. The I/O window holds a byte output FIFO drained by a valid/ready consumer (LEDs, display, UART shim) and a free-running cycle counter. Reads are combinational so the single-cycle core can consume ReadData within the same cycle; all state changes commit on the rising clock edge.

## Interface
- RAM_WORDS, 64: RAM depth in 32-bit words, power of two, at most 64 so the RAM fits 0x000–0x0FF.
- FIFO_DEPTH, 4: output FIFO entries, power of two, at least 2.
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-low; 0 at a rising edge resets.
- MemWrite  input  1  write strobe from the core.
- ALUResult  input  32  byte address; bits [1:0] ignored.
- WriteData  input  32  store data.
- ReadData  output  32  load data, combinational.
- out_data  output  8  FIFO head byte; 0 when empty.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head.

## Operation
- Address map, decoded on ALUResult[31:2]:
  - 0x000–0x0FF: RAM, index ALUResult[7:2]. Indices ≥ RAM_WORDS are unmapped.
  - 0x100 TXDATA: a write pushes WriteData[7:0]. A read returns {24'b0, head}.
  - 0x104 STATUS, read: bit0 full, bit1 empty, bit2 overflow, bits[7:3] count. Write: a 1 in bit2 clears overflow; all other bits are ignored.
  - 0x108 CYCLES: a read returns the counter. A write loads WriteData.
  - Everything else is unmapped: reads return 0, writes have no effect.
- RAM is not reset. Its contents are undefined until written.
- FIFO push to TXDATA while full and with no pop in the same cycle: the byte is dropped and overflow is set (sticky).
- Pop occurs when out_valid and out_ready are both 1 at the edge.
- Simultaneous push and pop while full: both take effect, count is unchanged, overflow is not set.
- Simultaneous push and pop while empty: the push is accepted and the pop is a no-op because out_valid is 0.
- Pointers wrap modulo FIFO_DEPTH. The count width is log2(FIFO_DEPTH)+1.
- Counter increments by 1 every cycle out of reset and wraps from 0xFFFFFFFF to 0.
  - On a CYCLES write edge the counter takes WriteData; the increment is suppressed in that cycle.

## Timing
- Reset values: out_valid 0, out_data 0, FIFO empty, overflow 0, counter 0.
  - ReadData follows the address decode. It is 0 for I/O registers in their reset state and undefined for unwritten RAM.
- Read latency is 0 cycles: ReadData is combinational from ALUResult and current state.
- Write latency is 1 edge: a store is visible to a load at the same address in the next cycle.
- A byte pushed at edge N drives out_valid=1 and out_data from N+1.
- A pop at edge N advances the head at N+1.
- Reset asserted mid-transfer: the FIFO is flushed and the pending handshake is abandoned. out_valid is 0 in the cycle after the reset edge.
- MemWrite is sampled only at clock edges.

## Configuration
- DMEM_CYCLE_COUNTER_EN defined: the cycle counter exists as described.
- Not defined: there is no counter register. 0x108 reads 0 and writes to it are ignored (it behaves as unmapped).

## Structure
- Package dmem_pkg holds:
  - address constants: ADDR_TXDATA=0x100, ADDR_STATUS=0x104, ADDR_CYCLES=0x108, RAM_LIMIT=0x100;
  - STATUS bit-index constants: ST_FULL=0, ST_EMPTY=1, ST_OVF=2, ST_COUNT_LSB=3;
  - an enumerated decode type {SEL_RAM, SEL_TX, SEL_STATUS, SEL_CYCLES, SEL_NONE}.
- Sub-module mmio_fifo: parameterised byte FIFO with push/pop, full/empty/count outputs, and a synchronous active-low reset.
- The top level contains address decode, RAM array, counter, overflow flag and ReadData mux.

## Test plan
- Reset, then store 0xDEADBEEF to 0x04 and load 0x04 next cycle → ReadData=0xDEADBEEF. A load at 0x200 → 0.
- With out_ready=0, push 0x11,0x22,0x33,0x44 → STATUS=0x21 (full, count 4). A fifth push of 0x55 → STATUS bit2=1 and count stays 4. Write STATUS=0x4 → bit2 clears.
- With the FIFO full and out_ready=1, push 0x66 → 0x11 pops and count stays 4. Drain → output order 0x22,0x33,0x44,0x66, then out_valid=0 and out_data=0.
- With DMEM_CYCLE_COUNTER_EN: write 0xFFFFFFFE to 0x108 → the next read gives 0xFFFFFFFE, then 0xFFFFFFFF, then 0 (wrap). Without the macro, the read is 0.
- Two entries queued, assert reset=0 for one cycle mid-drain → out_valid=0 and STATUS=0x02 after release. The counter restarts from 0.
- Load from 0x107 → identical to 0x104 (bits [1:0] ignored).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared address map and decode types for the data-side memory/MMIO responder.
package dmem_pkg;

    localparam logic [31:0] ADDR_TXDATA = 32'h100;
    localparam logic [31:0] ADDR_STATUS = 32'h104;
    localparam logic [31:0] ADDR_CYCLES = 32'h108;
    localparam logic [31:0] RAM_LIMIT   = 32'h100;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 3;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_TX,
        SEL_STATUS,
        SEL_CYCLES,
        SEL_NONE
    } sel_t;

endpackage

// File: rtl/dmem_mmio_if.sv
// Core data port plus the byte output stream of the MMIO window.
interface dmem_mmio_if;

    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output MemWrite, ALUResult, WriteData, out_ready,
        input  ReadData, out_data, out_valid
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData, out_ready,
        output ReadData, out_data, out_valid
    );

endinterface

// File: rtl/mmio_fifo.sv
// Byte FIFO for the MMIO output stream; head reads as 0 when empty.
module mmio_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // a pop frees a slot in the same edge, so a full FIFO still accepts
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dmem_mmio.sv
// Word RAM plus MMIO window (TX FIFO, STATUS, optional CYCLES counter).
// Define DMEM_CYCLE_COUNTER_EN to build the cycle counter at 0x108.
module dmem_mmio
    import dmem_pkg::*;
#(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    dmem_mmio_if.slave  bus
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   addr;
    sel_t          sel;
    logic [31:0]   ram [RAM_WORDS];
    logic [AW-1:0] ram_idx;
    logic          tx_push;
    logic          tx_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [7:0]    fifo_head;
    logic          ovf;
    logic [31:0]   status;
    logic          unused_ok;

    assign addr    = {bus.ALUResult[31:2], 2'b00};
    assign ram_idx = bus.ALUResult[2 +: AW];

    always_comb begin
        sel = SEL_NONE;
        unique case (1'b1)
            (addr < RAM_LIMIT):
                sel = (32'(addr[7:2]) < 32'(RAM_WORDS)) ? SEL_RAM : SEL_NONE;
            (addr == ADDR_TXDATA): sel = SEL_TX;
            (addr == ADDR_STATUS): sel = SEL_STATUS;
`ifdef DMEM_CYCLE_COUNTER_EN
            (addr == ADDR_CYCLES): sel = SEL_CYCLES;
`endif
            default: sel = SEL_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (bus.MemWrite && sel == SEL_RAM) begin
            ram[ram_idx] <= bus.WriteData;
        end
    end

    assign tx_push = bus.MemWrite && (sel == SEL_TX);
    assign tx_pop  = bus.out_valid && bus.out_ready;

    mmio_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst_n(reset),
        .push (tx_push),
        .din  (bus.WriteData[7:0]),
        .pop  (tx_pop),
        .dout (fifo_head),
        .full (fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_data  = fifo_head;

    // overflow only when the byte is really dropped (no pop frees a slot)
    always_ff @(posedge clk) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (tx_push && fifo_full && !tx_pop) begin
            ovf <= 1'b1;
        end else if (bus.MemWrite && sel == SEL_STATUS
                     && bus.WriteData[ST_OVF]) begin
            ovf <= 1'b0;
        end
    end

    always_comb begin
        status = '0;
        status[ST_FULL]  = fifo_full;
        status[ST_EMPTY] = fifo_empty;
        status[ST_OVF]   = ovf;
        status[ST_COUNT_LSB +: CW] = fifo_count;
    end

`ifdef DMEM_CYCLE_COUNTER_EN
    logic [31:0] cycles;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cycles <= '0;
        end else if (bus.MemWrite && sel == SEL_CYCLES) begin
            cycles <= bus.WriteData;
        end else begin
            cycles <= cycles + 32'd1;
        end
    end

    assign unused_ok = ^bus.ALUResult[1:0];
`else
    assign unused_ok = ^{bus.ALUResult[1:0], bus.WriteData[31:8]};
`endif

    always_comb begin
        bus.ReadData = '0;
        unique case (sel)
            SEL_RAM:    bus.ReadData = ram[ram_idx];
            SEL_TX:     bus.ReadData = {24'b0, fifo_head};
            SEL_STATUS: bus.ReadData = status;
`ifdef DMEM_CYCLE_COUNTER_EN
            SEL_CYCLES: bus.ReadData = cycles;
`endif
            default:    bus.ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// Randomized scoreboard bench for dmem_mmio against a queue-based model.
module tb_dmem_mmio;

    localparam int DEPTH = 4;
`ifdef DMEM_CYCLE_COUNTER_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_mmio_if bus();

    dmem_mmio #(
        .RAM_WORDS (64),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        bit          chk_rd;
        logic [31:0] rd;
        bit          chk_out;
        logic        ov;
        logic [7:0]  od;
        string       tag;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad = 0;

    logic [31:0] m_ram [int];
    logic [7:0]  m_fifo[$];
    bit          m_ovf = 1'b0;
    logic [31:0] m_cnt = '0;
    bit          live = 1'b0;

    function automatic logic [31:0] m_read(input logic [31:0] ai,
                                           output bit def);
        logic [31:0] a;
        int n;
        a = {ai[31:2], 2'b00};
        n = m_fifo.size();
        def = 1'b1;
        if (a < 32'h100) begin
            if (m_ram.exists(int'(a[7:2]))) return m_ram[int'(a[7:2])];
            def = 1'b0;
            return 32'h0;
        end
        case (a)
            32'h100: return (n != 0) ? {24'b0, m_fifo[0]} : 32'h0;
            32'h104: return {24'b0, 5'(n), m_ovf, (n == 0), (n == DEPTH)};
            32'h108: return CNT_EN ? m_cnt : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input bit rst, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input bit rdy,
                        input bit chk, input string tag);
        exp_t e;
        bit def;
        logic [31:0] al;
        @(posedge clk);
        #1;
        reset = ~rst;
        bus.MemWrite  = we;
        bus.ALUResult = a;
        bus.WriteData = wd;
        bus.out_ready = rdy;
        e.rd      = m_read(a, def);
        e.chk_rd  = live && chk && def;
        e.chk_out = live;
        e.ov      = (m_fifo.size() != 0);
        e.od      = (m_fifo.size() != 0) ? m_fifo[0] : 8'h00;
        e.tag     = tag;
        sbq.push_back(e);
        al = {a[31:2], 2'b00};
        if (rst) begin
            m_fifo.delete();
            m_ovf = 1'b0;
            m_cnt = '0;
            live  = 1'b1;
        end else begin
            if (m_fifo.size() != 0 && rdy) void'(m_fifo.pop_front());
            if (we) begin
                if (al < 32'h100) begin
                    m_ram[int'(al[7:2])] = wd;
                end else if (al == 32'h100) begin
                    if (m_fifo.size() < DEPTH) m_fifo.push_back(wd[7:0]);
                    else m_ovf = 1'b1;
                end else if (al == 32'h104 && wd[2]) begin
                    m_ovf = 1'b0;
                end
            end
            if (CNT_EN && we && al == 32'h108) m_cnt = wd;
            else m_cnt = m_cnt + 32'd1;
        end
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (sbq.size() != 0) begin
            me = sbq.pop_front();
            if (me.chk_rd) begin
                total++;
                if (bus.ReadData !== me.rd) begin
                    bad++;
                    $display("FAIL %s rdata got=%h exp=%h",
                             me.tag, bus.ReadData, me.rd);
                end
            end
            if (me.chk_out) begin
                total++;
                if (bus.out_valid !== me.ov || bus.out_data !== me.od) begin
                    bad++;
                    $display("FAIL %s stream got=%b/%h exp=%b/%h", me.tag,
                             bus.out_valid, bus.out_data, me.ov, me.od);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        bit we;
        int r;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = '0;
        bus.WriteData = '0;
        bus.out_ready = 1'b0;

        step(1, 0, 32'h0, 0, 0, 0, "rst0");
        step(1, 0, 32'h104, 0, 0, 1, "rst1");
        step(0, 0, 32'h104, 0, 0, 1, "st_reset");
        step(0, 0, 32'h100, 0, 0, 1, "tx_reset");
        step(0, 1, 32'h04, 32'hDEADBEEF, 0, 0, "st_ram");
        step(0, 0, 32'h04, 0, 0, 1, "ld_ram");
        step(0, 0, 32'h200, 0, 0, 1, "ld_unmapped");

        step(0, 1, 32'h100, 32'h11, 0, 0, "push11");
        step(0, 1, 32'h100, 32'h22, 0, 0, "push22");
        step(0, 1, 32'h100, 32'h33, 0, 0, "push33");
        step(0, 1, 32'h100, 32'h44, 0, 0, "push44");
        step(0, 0, 32'h104, 0, 0, 1, "st_full");
        step(0, 1, 32'h100, 32'h55, 0, 0, "push55");
        step(0, 0, 32'h104, 0, 0, 1, "st_ovf");
        step(0, 1, 32'h104, 32'h4, 0, 0, "clr_ovf");
        step(0, 0, 32'h104, 0, 0, 1, "st_clr");

        step(0, 1, 32'h100, 32'h66, 1, 1, "push_pop_full");
        step(0, 0, 32'h104, 0, 0, 1, "st_after_pp");
        for (int i = 0; i < 6; i++) step(0, 0, 32'h100, 0, 1, 1, "drain");
        step(0, 0, 32'h104, 0, 0, 1, "st_drained");

        step(0, 1, 32'h108, 32'hFFFFFFFE, 0, 0, "cyc_wr");
        for (int i = 0; i < 3; i++) step(0, 0, 32'h108, 0, 0, 1, "cyc_rd");

        step(0, 1, 32'h100, 32'hA1, 0, 0, "pushA1");
        step(0, 1, 32'h100, 32'hA2, 0, 0, "pushA2");
        step(0, 0, 32'h100, 0, 1, 1, "drainA");
        step(1, 0, 32'h100, 0, 1, 1, "rst_mid");
        step(0, 0, 32'h104, 0, 1, 1, "st_after_rst");
        step(0, 0, 32'h108, 0, 0, 1, "cyc_after_rst");
        step(0, 1, 32'h100, 32'h5A, 0, 0, "push5A");
        step(0, 0, 32'h107, 0, 0, 1, "st_107");
        step(0, 0, 32'h104, 0, 0, 1, "st_104");

        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r < 3) a = 32'($urandom_range(0, 63) * 4 + $urandom_range(0, 3));
            else if (r < 6) a = 32'h100 + 32'($urandom_range(0, 3));
            else if (r < 8) a = 32'h104 + 32'($urandom_range(0, 3));
            else if (r == 8) a = 32'h108 + 32'($urandom_range(0, 3));
            else begin
                a = $urandom;
                if (a < 32'h10C) a = a | 32'h1000;
            end
            we = ($urandom_range(0, 2) == 0);
            step(0, we, a, $urandom, ($urandom_range(0, 3) == 0), 1, "rand");
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
